// File: rtl/l3_mem_pkg.sv
// Shared definitions for the l3_mem dual-port memory slice: FSM state encoding
// and default geometry.
package l3_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;

endpackage

// File: rtl/l3_mem_arb.sv
// Dual-port arbiter: detects same-address conflicts involving a write and
// resolves them with a round-robin pointer that toggles on every conflict.
module l3_mem_arb
  import l3_mem_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          grant0,
  output logic          grant1
);

  logic conflict_s;
  logic rr_r;

  // Two reads to the same word never conflict; any write to a shared word does.
  always_comb begin
    conflict_s = en & req0 & req1 & (addr0 == addr1) & (we0 | we1);
    grant0     = en & req0 & (~conflict_s | ~rr_r);
    grant1     = en & req1 & (~conflict_s | rr_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_r <= 1'b0;
    end else if (conflict_s) begin
      rr_r <= ~rr_r;
    end else begin
      rr_r <= rr_r;
    end
  end

endmodule

// File: rtl/l3_mem_dp2.sv
// Dual-port synchronous RAM with arbitration and registered outputs.
// Define L3_MEM_INIT_SWEEP_EN to clear the array with a post-reset sweep.
module l3_mem_dp2
  import l3_mem_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic          ACK0,
  output logic          ACK1,
  output logic          READY
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  state_t        state_r;
  state_t        state_nxt_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          ack0_r;
  logic          ack1_r;
  logic          ready_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;

`ifdef L3_MEM_INIT_SWEEP_EN
  logic [AW-1:0] cnt_r;
  logic [AW-1:0] cnt_nxt_s;
  logic          sweep_s;
`endif

  l3_mem_arb #(.AW(AW)) u_arb (
    .clk    (CLK),
    .rst    (RES),
    .en     (state_r == ST_RUN),
    .req0   (REQ0),
    .req1   (REQ1),
    .we0    (WE0),
    .we1    (WE1),
    .addr0  (ADDR0),
    .addr1  (ADDR1),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  always_comb begin
    state_nxt_s = state_r;
`ifdef L3_MEM_INIT_SWEEP_EN
    cnt_nxt_s   = cnt_r;
    sweep_s     = 1'b0;
`endif
    case (state_r)
      ST_INIT: begin
`ifdef L3_MEM_INIT_SWEEP_EN
        sweep_s   = 1'b1;
        cnt_nxt_s = cnt_r + AW'(1);
        if (&cnt_r) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
`else
        state_nxt_s = ST_RUN;
`endif
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_r <= ST_INIT;
`ifdef L3_MEM_INIT_SWEEP_EN
      cnt_r   <= {AW{1'b0}};
`endif
    end else begin
      state_r <= state_nxt_s;
`ifdef L3_MEM_INIT_SWEEP_EN
      cnt_r   <= cnt_nxt_s;
`endif
    end
  end

  // The array itself is never reset; grants are zero while sweeping.
  always_ff @(posedge CLK) begin
`ifdef L3_MEM_INIT_SWEEP_EN
    if (sweep_s) begin
      mem[cnt_r] <= {DW{1'b0}};
    end
`endif
    if (grant0_s & WE0) begin
      mem[ADDR0] <= WDATA0;
    end
    if (grant1_s & WE1) begin
      mem[ADDR1] <= WDATA1;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      ready_r  <= 1'b0;
      rdata0_r <= {DW{1'b0}};
      rdata1_r <= {DW{1'b0}};
    end else begin
      ack0_r  <= grant0_s;
      ack1_r  <= grant1_s;
      ready_r <= (state_nxt_s == ST_RUN);
      if (grant0_s & ~WE0) begin
        rdata0_r <= mem[ADDR0];
      end
      if (grant1_s & ~WE1) begin
        rdata1_r <= mem[ADDR1];
      end
    end
  end

  assign ACK0   = ack0_r;
  assign ACK1   = ack1_r;
  assign READY  = ready_r;
  assign RDATA0 = rdata0_r;
  assign RDATA1 = rdata1_r;

endmodule

// File: tb/tb_l3_mem_dp2.sv
// Directed scoreboard bench for l3_mem_dp2 (DW=8, AW=4); honours
// L3_MEM_INIT_SWEEP_EN for the expected READY latency and cleared contents.
module tb_l3_mem_dp2;

`ifdef L3_MEM_INIT_SWEEP_EN
  localparam int INIT_LAT = 16;
`else
  localparam int INIT_LAT = 1;
`endif

  logic       CLK = 1'b0;
  logic       RES;
  logic       REQ0, REQ1, WE0, WE1;
  logic [3:0] ADDR0, ADDR1;
  logic [7:0] WDATA0, WDATA1;
  logic [7:0] RDATA0, RDATA1;
  logic       ACK0, ACK1, READY;

  int         n_cmp = 0;
  int         n_err = 0;
  logic       exp_ack0 = 1'b0, exp_ack1 = 1'b0;
  logic       exp_rd0 = 1'b0, exp_rd1 = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  l3_mem_dp2 #(.DW(8), .AW(4)) dut (
    .CLK(CLK), .RES(RES),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .ACK0(ACK0), .ACK1(ACK1), .READY(READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // acc: whether the bench expects this request to win this cycle.
  task automatic drive0(input logic req, input logic we, input logic [3:0] addr,
                        input logic [7:0] wd, input logic acc, input logic [7:0] rd);
    REQ0 = req; WE0 = we; ADDR0 = addr; WDATA0 = wd;
    exp_ack0 = acc;
    exp_rd0  = acc & ~we;
    if (acc && !we) q0.push_back(rd);
  endtask

  task automatic drive1(input logic req, input logic we, input logic [3:0] addr,
                        input logic [7:0] wd, input logic acc, input logic [7:0] rd);
    REQ1 = req; WE1 = we; ADDR1 = addr; WDATA1 = wd;
    exp_ack1 = acc;
    exp_rd1  = acc & ~we;
    if (acc && !we) q1.push_back(rd);
  endtask

  task automatic idle();
    drive0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic tick(input string tag);
    @(posedge CLK);
    #1;
    chk({tag, "_ack0"}, {7'b0, ACK0}, {7'b0, exp_ack0});
    chk({tag, "_ack1"}, {7'b0, ACK1}, {7'b0, exp_ack1});
    if (exp_rd0) chk({tag, "_rd0"}, RDATA0, q0.pop_front());
    if (exp_rd1) chk({tag, "_rd1"}, RDATA1, q1.pop_front());
  endtask

  // Holds a write request during init; it must be ignored.
  task automatic wait_ready(input string tag);
    int n = 0;
    idle();
    REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 4'd5; WDATA0 = 8'hFF;
    while (READY !== 1'b1 && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      chk({tag, "_noack"}, {7'b0, ACK0}, 8'h00);
    end
    idle();
    chk(tag, 8'(n), 8'(INIT_LAT));
  endtask

  initial begin
    RES = 1'b1;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", {7'b0, READY}, 8'h00);
    chk("rst_ack0", {7'b0, ACK0}, 8'h00);
    chk("rst_ack1", {7'b0, ACK1}, 8'h00);
    chk("rst_rdata0", RDATA0, 8'h00);
    chk("rst_rdata1", RDATA1, 8'h00);

    RES = 1'b0;
    wait_ready("ready_lat");
`ifdef L3_MEM_INIT_SWEEP_EN
    for (int i = 0; i < 16; i++) begin
      drive0(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 8'h00);
      tick("sweep_rd");
    end
    idle();
`endif

    drive0(1'b1, 1'b1, 4'd0, 8'h3C, 1'b1, 8'h00);  tick("wr_a0");
    drive0(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 8'h3C);  tick("rd_a0");
    idle();                                          tick("idle");

    drive0(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 8'h00);  tick("wr_a3");
    drive0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive1(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'hA5);  tick("x_rd_a3");

    drive1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive0(1'b1, 1'b1, 4'd2, 8'h5A, 1'b1, 8'h00);  tick("wr_a2");
    drive0(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 8'h5A);
    drive1(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 8'h5A);  tick("dual_rd");

    // Same-address write/write with both ports holding: port 0 wins first.
    drive0(1'b1, 1'b1, 4'd7, 8'h11, 1'b1, 8'h00);
    drive1(1'b1, 1'b1, 4'd7, 8'h22, 1'b0, 8'h00);  tick("conf_a");
    drive0(1'b1, 1'b1, 4'd7, 8'h11, 1'b0, 8'h00);
    drive1(1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 8'h00);  tick("conf_b");
    drive1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive0(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 8'h22);  tick("rd_a7");

    drive0(1'b1, 1'b1, 4'd9, 8'h01, 1'b1, 8'h00);
    drive1(1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 8'h00);  tick("rr_p0");
    drive0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive1(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 8'h01);  tick("rr_rd");
    drive0(1'b1, 1'b1, 4'd10, 8'hAA, 1'b0, 8'h00);
    drive1(1'b1, 1'b1, 4'd10, 8'hBB, 1'b1, 8'h00); tick("rr_p1");
    drive0(1'b1, 1'b1, 4'd10, 8'hAA, 1'b1, 8'h00);
    drive1(1'b1, 1'b1, 4'd10, 8'hBB, 1'b0, 8'h00); tick("rr_p0b");
    drive1(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive0(1'b1, 1'b0, 4'd10, 8'h00, 1'b1, 8'hAA); tick("rd_a10");

    drive0(1'b1, 1'b1, 4'd4, 8'hEE, 1'b1, 8'h00);
    drive1(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'hA5);  tick("diff_a");
    drive0(1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 8'hEE);
    drive1(1'b1, 1'b1, 4'd3, 8'hC3, 1'b1, 8'h00);  tick("diff_b");
    drive0(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00);
    drive1(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'hC3);  tick("rd_a3b");
    idle();                                          tick("hold");
    chk("hold_rdata0", RDATA0, 8'hEE);
    chk("hold_rdata1", RDATA1, 8'hC3);

    // Asynchronous reset between clock edges clears outputs at once.
    drive0(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 8'h22);  tick("pre_rst");
    #2;
    RES = 1'b1;
    #1;
    chk("async_ack0", {7'b0, ACK0}, 8'h00);
    chk("async_rdata0", RDATA0, 8'h00);
    chk("async_ready", {7'b0, READY}, 8'h00);
    idle();
    @(posedge CLK);
    #1;
    RES = 1'b0;
`ifdef L3_MEM_INIT_SWEEP_EN
    repeat (9) @(posedge CLK);
    #1;
    chk("mid_sweep_ready", {7'b0, READY}, 8'h00);
    RES = 1'b1;
    #2;
    RES = 1'b0;
`endif
    wait_ready("ready_lat2");
`ifdef L3_MEM_INIT_SWEEP_EN
    drive0(1'b1, 1'b0, 4'd10, 8'h00, 1'b1, 8'h00); tick("clr_a10");
    drive0(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 8'h00);  tick("clr_a5");
`endif
    drive0(1'b1, 1'b1, 4'd0, 8'h3C, 1'b1, 8'h00);  tick("wr_a0b");
    drive0(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 8'h3C);  tick("rd_a0b");
    idle();                                          tick("end");
    chk("q0_empty", 8'(q0.size()), 8'h00);
    chk("q1_empty", 8'(q1.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
